multiword_add_seq: RTL and testbench
====================================

// Module: multiword_add_seq
// PURPOSE
//  Sequencer that performs an N=W*K-bit add/subtract by pushing one W-bit slice per
//  clock through a single W-bit adder stage, chaining the carry between slices.
//  Sits between a command source (start/ready handshake) and consumers of a wide
//  sum; trades K cycles of latency for a W-bit carry chain.
// PARAMETERS
//  W  8  slice width (bits added per cycle), >=1
//  K  4  number of slices, >=1; operand width N = W*K
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous reset, active-low
//  start      in   1    request; accepted only when ready=1
//  sub        in   1    0: A+B, 1: A-B; sampled with start
//  op_a       in   N    operand A; sampled with start
//  op_b       in   N    operand B; sampled with start
//  ready      out  1    1 in IDLE (can accept start)
//  busy       out  1    1 in RUN; always equals ~ready
//  result     out  N    sum/difference; updated only at completion
//  carry_out  out  1    carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1    signed two's-complement overflow
//  done       out  1    one-cycle pulse: result/carry_out/ovf just updated
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, result=0, carry_out=0, ovf=0, done=0,
//   ready=1, busy=0, internal operand/carry/index regs cleared.
//  FSM: IDLE, RUN.
//   IDLE: ready=1. Edge with start=1: capture op_a, op_b^{N{sub}}, sub into shift regs;
//    chain carry c<=sub; idx<=0; -> RUN. start=0: stay.
//   RUN: each edge adds slice idx: {c,s} = a[W-1:0] + b'[W-1:0] + c; s shifted into a
//    scratch reg from the MSB end; a, b' shift right by W; idx++.
//    On edge where idx==K-1: result<=assembled value, carry_out<=final c,
//    ovf<=(a_msb ~^ b'_msb) & (s_msb ^ a_msb), done<=1, -> IDLE.
//  Latency: start sampled at edge E0; done=1 in cycle after edge E0+K (K cycles).
//  Throughput: one op per K+1 cycles; start may be asserted in the cycle done=1
//   (ready=1 then) and is accepted.
//  start while busy: ignored, no effect on in-flight op or captured operands.
//  op_a/op_b/sub changing during RUN: no effect.
//  result/carry_out/ovf hold their values from done until next completion; never
//   show intermediate slices.
//  done: exactly one cycle per accepted start; never asserted after reset abort.
//  Reset mid-RUN: op discarded, outputs to reset values, no done pulse.
//  K=1: single-cycle RUN, done one cycle after start edge.
//  All arithmetic modulo 2^N; carry/ovf as defined above, no saturation.
// TESTING (W=8, K=4)
//  1 rst_n=0 -> result=0, carry_out=0, ovf=0, done=0, ready=1, busy=0.
//  2 add 0xFFFFFFFF+0x00000001 -> result=0x00000000, carry_out=1, ovf=0;
//    done exactly 4 cycles after start edge, busy=1 for 4 cycles.
//  3 sub 0x00000005-0x00000007 -> result=0xFFFFFFFE, carry_out=0, ovf=0;
//    sub 0x12345678-0x00000000 -> 0x12345678, carry_out=1.
//  4 add 0x7FFFFFFF+0x00000001 -> result=0x80000000, ovf=1, carry_out=0;
//    sub 0x80000000-0x00000001 -> 0x7FFFFFFF, ovf=1, carry_out=1.
//  5 start held high continuously with new operands -> ops accepted every 5 cycles,
//    start during busy ignored, each done carries the correct result.
//  6 rst_n low in 2nd RUN cycle of 0x11111111+0x22222222 -> outputs reset, no done;
//    next op 0x00000001+0x00000002 -> result=0x00000003.

Source files
------------

// File: rtl/multiword_add_seq_if.sv
// Command/result bundle for the sliced wide adder.
// master: command source + result consumer; slave: the sequencer.
interface multiword_add_seq_if #(
  parameter int W = 8,
  parameter int K = 4
);
  localparam int N = W * K;

  logic         start;
  logic         sub;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         ready;
  logic         busy;
  logic [N-1:0] result;
  logic         carry_out;
  logic         ovf;
  logic         done;

  modport master (
    output start, sub, op_a, op_b,
    input  ready, busy, result, carry_out, ovf, done
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output ready, busy, result, carry_out, ovf, done
  );
endinterface

// File: rtl/multiword_add_seq.sv
// N=W*K add/sub done one W-bit slice per clock, carry chained.
// Ports: clk, rst_n (async low), bus (slave): start/sub/op_a/op_b in; ready/busy/result/carry_out/ovf/done out.
module multiword_add_seq #(
  parameter int W = 8,
  parameter int K = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multiword_add_seq_if.slave bus
);
  localparam int N  = W * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    s_q, s_d;
  logic            c_q, c_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    res_q, res_d;
  logic            co_q, co_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [W:0]      sum;
  logic [N-1:0]    s_ins;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    idx_d   = idx_q;
    res_d   = res_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    sum = {1'b0, a_q[W-1:0]}
        + {1'b0, b_q[W-1:0]}
        + {{W{1'b0}}, c_q};

    // new slice enters at the top; after K shifts
    // slice 0 has reached bit 0
    s_ins        = '0;
    s_ins[W-1:0] = sum[W-1:0];
    s_ins        = s_ins << (N - W);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b ^ {N{bus.sub}};
          c_d     = bus.sub;
          s_d     = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d   = sum[W];
        s_d   = (s_q >> W) | s_ins;
        a_d   = a_q >> W;
        b_d   = b_q >> W;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(K - 1)) begin
          res_d   = s_d;
          co_d    = sum[W];
          ovf_d   = (a_q[W-1] ~^ b_q[W-1])
                  & (sum[W-1] ^ a_q[W-1]);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.result    = res_q;
  assign bus.carry_out = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (W=8, K=4).
// Vector table, back-to-back start, mid-run reset.
module tb_multiword_add_seq;
  localparam int W = 8;
  localparam int K = 4;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multiword_add_seq_if #(.W(W), .K(K)) bus ();
  multiword_add_seq #(.W(W), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name,
                     input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic s,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] bb;
    logic [32:0] t;
    logic        o;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + 33'(s);
    o  = (a[31] == bb[31]) && (t[31] != a[31]);
    return {t[32], o, t[31:0]};
  endfunction

  task automatic run_op(input logic s,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input string tag,
                        input logic [31:0] er,
                        input logic ec,
                        input logic eo);
    int cyc;
    int bcnt;
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = ~a;
    bus.op_b  = ~b;
    bus.sub   = ~s;
    bcnt = bus.busy ? 1 : 0;
    cyc  = 0;
    got  = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.busy) bcnt++;
      if (bus.done) got = 1'b1;
    end
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'd4);
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'd4);
    chk({tag, " result"}, bus.result, er);
    chk({tag, " carry_out"}, 32'(bus.carry_out), 32'(ec));
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
    chk({tag, " ready"}, 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  logic [33:0] expq [$];
  int          acc_e [$];
  int          done_e [$];
  logic [33:0] e;
  bit          rdy;
  int          ndone;

  initial begin
    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    #1;
    chk("rst result", bus.result, 32'h0);
    chk("rst carry_out", 32'(bus.carry_out), 32'd0);
    chk("rst ovf", 32'(bus.ovf), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst ready", 32'(bus.ready), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b,
             $sformatf("vec%0d", i),
             vecs[i].res, vecs[i].co, vecs[i].ov);
    end

    // start held high: accepted every K+1 cycles
    for (int j = 0; j < 27; j++) begin
      @(negedge clk);
      bus.start = (j <= 20);
      bus.sub   = ((j % 2) == 1);
      bus.op_a  = 32'h01234567 * (j + 1);
      bus.op_b  = 32'h89ABCDEF ^ (j * 32'h11111111);
      rdy       = bus.ready;
      @(posedge clk);
      #1;
      if (rdy && bus.start) begin
        expq.push_back(model(bus.sub, bus.op_a, bus.op_b));
        acc_e.push_back(j);
      end
      if (bus.done) begin
        done_e.push_back(j);
        if (expq.size() == 0) begin
          chk("b2b unexpected done", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("b2b result", bus.result, e[31:0]);
          chk("b2b carry_out", 32'(bus.carry_out), 32'(e[33]));
          chk("b2b ovf", 32'(bus.ovf), 32'(e[32]));
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b accepts", 32'(acc_e.size()), 32'd5);
    chk("b2b dones", 32'(done_e.size()), 32'd5);
    for (int i = 0; i < acc_e.size(); i++) begin
      chk("b2b accept_edge", 32'(acc_e[i]), 32'(5 * i));
    end
    for (int i = 0; i < done_e.size(); i++) begin
      chk("b2b done_edge", 32'(done_e[i]), 32'(5 * i + 4));
    end

    // reset in the 2nd RUN cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.op_a  = 32'h11111111;
    bus.op_b  = 32'h22222222;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort result", bus.result, 32'h0);
    chk("abort carry_out", 32'(bus.carry_out), 32'd0);
    chk("abort ovf", 32'(bus.ovf), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort ready", 32'(bus.ready), 32'd1);
    chk("abort busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("abort no_done", 32'(ndone), 32'd0);
    chk("abort busy_after", 32'(bus.busy), 32'd0);
    run_op(1'b0, 32'h00000001, 32'h00000002, "post_abort",
           32'h00000003, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
